spi_master_fifo_wr_arbiter: RTL and testbench
=============================================

// Module: spi_master_fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one SPI master TX FIFO write port between NUM_REQ requesters.
//  A granted requester owns the port until its burst ends (last beat) or MAX_BURST beats are pushed.
//  Bursts are never interleaved in the FIFO.
//  Sits between the APB register front-end/uDMA-style requesters and the TX FIFO valid/ready input.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2)
//  DATA_WIDTH  32  word width, equals TX FIFO DATA_WIDTH
//  MAX_BURST   16  beats after which ownership is forcibly released (>=1)
// PORTS
//  clk_i        in   1                     clock
//  rst_ni       in   1                     reset, synchronous, active-low
//  clr_i        in   1                     synchronous abort; same effect as reset
//  req_valid_i  in   NUM_REQ               per-requester word valid
//  req_last_i   in   NUM_REQ               per-requester last beat of burst (qualified by valid)
//  req_data_i   in   NUM_REQ*DATA_WIDTH    packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready_o  out  NUM_REQ               per-requester accept
//  fifo_valid_o out  1                     to FIFO valid_i
//  fifo_data_o  out  DATA_WIDTH            to FIFO data_i
//  fifo_ready_i in   1                     from FIFO ready_o (not full)
//  grant_o      out  NUM_REQ               one-hot current owner, 0 when idle
//  busy_o       out  1                     1 while state=LOCK
// BEHAVIOUR
//  Sampling: all state updates on posedge clk_i. When rst_ni==0 (sampled at edge):
//   state=IDLE, owner=0, rr_ptr=NUM_REQ-1, beat_cnt=0.
//  Reset outputs: grant_o=0, busy_o=0, fifo_valid_o=0, fifo_data_o=0, req_ready_o=0.
//  clr_i (rst_ni=1): identical reset of state; takes priority over any transfer that cycle.
//   A word handshaken combinationally in that cycle is still written by the FIFO; the arbiter drops ownership.
//  FSM IDLE:
//   - If any req_valid_i: choose first valid index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
//   - Next cycle: state=LOCK, owner=choice, rr_ptr=choice, beat_cnt=0.
//   - No transfer occurs in IDLE.
//   - Request-to-first-beat latency is 1 cycle.
//  FSM LOCK:
//   - fifo_valid_o = req_valid_i[owner].
//   - fifo_data_o = word[owner].
//   - req_ready_o[owner] = fifo_ready_i; all other req_ready_o = 0.
//   - All three are combinational (no added latency).
//   - beat = fifo_valid_o & fifo_ready_i.
//   - On beat: beat_cnt+1.
//   - On beat with req_last_i[owner]=1 OR beat_cnt==MAX_BURST-1: next state=IDLE, beat_cnt=0.
//   - Owner valid low while locked: hold LOCK indefinitely; no timeout.
//  Outside LOCK: fifo_valid_o=0, fifo_data_o=0, req_ready_o=0.
//  grant_o = LOCK ? (1<<owner) : 0.
//  Release always costs one IDLE cycle before the next grant.
//  Round robin: the just-served requester has lowest priority at the next arbitration.
//  Requester that drops valid in IDLE before grant: not remembered; no pending state.
//  FIFO full (fifo_ready_i=0): owner stalls, beat_cnt unchanged; data/valid held by requester per valid/ready rule.
//  beat_cnt width: enough bits to hold MAX_BURST-1 (1 bit min); never wraps in LOCK.
// TESTING
//  1. Reset, then req0 burst 3 words (last on 3rd), fifo_ready=1:
//     grant_o=01 in cycle 1; 3 beats in cycles 1..3; IDLE in cycle 4; FIFO holds A,B,C in order.
//  2. req0 and req1 both valid continuously after reset:
//     grants alternate 01,10,01,...; bursts are never interleaved in FIFO contents.
//  3. req1 streams 40 words with no last, MAX_BURST=16, req0 valid:
//     release after beat 16, then req0 granted; req1 resumes after req0's burst.
//  4. fifo_ready_i=0 for 5 cycles mid-burst:
//     no beats; req_ready_o[owner]=0; beat_cnt frozen; burst completes intact after ready returns.
//  5. clr_i pulse (or rst_ni low 1 cycle) mid-burst of req1:
//     next cycle busy_o=0, grant_o=0; next arbitration favours req0 (rr_ptr=NUM_REQ-1).
//  6. Owner deasserts valid for 4 cycles while locked, other requester valid:
//     ownership kept, no beats, other req_ready_o stays 0.

Source files
------------

// File: rtl/spi_master_fifo_wr_arbiter.sv
// Round-robin arbiter that shares one SPI TX FIFO write port between several
// burst requesters. The owner keeps the port until its last beat or until
// MAX_BURST beats have been pushed, so bursts never interleave in the FIFO.
module spi_master_fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clr_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_valid_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  input  logic                          fifo_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [OW-1:0] RR_RST   = OW'(NUM_REQ - 1);

  typedef enum logic {ST_IDLE, ST_LOCK} state_e;

  state_e               state_q;
  logic [OW-1:0]        owner_q;
  logic [OW-1:0]        rr_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic [NUM_REQ-1:0]   grant_q;

  logic [2*NUM_REQ-1:0] dbl_c;
  logic [NUM_REQ-1:0]   rot_c;
  logic                 pick_found_c;
  logic [OW-1:0]        pick_idx_c;
  logic                 owner_valid_c;
  logic                 owner_last_c;
  logic [DATA_WIDTH-1:0] owner_data_c;
  logic [NUM_REQ-1:0]   owner_oh_c;
  logic                 lock_c;
  logic                 beat_c;

  // Round-robin pick: rotate valids so bit 0 is the requester after rr_ptr.
  always_comb begin
    dbl_c        = {req_valid_i, req_valid_i};
    rot_c        = NUM_REQ'(dbl_c >> (32'(rr_ptr_q) + 32'd1));
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!pick_found_c && rot_c[j]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = OW'((32'(rr_ptr_q) + 32'd1 + j) % NUM_REQ);
      end
    end
  end

  // Select the current owner's request signals.
  always_comb begin
    owner_valid_c = 1'b0;
    owner_last_c  = 1'b0;
    owner_data_c  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        owner_valid_c = req_valid_i[i];
        owner_last_c  = req_last_i[i];
        owner_data_c  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pass-through of the owner onto the FIFO port while locked.
  always_comb begin
    lock_c       = (state_q == ST_LOCK);
    owner_oh_c   = NUM_REQ'(1) << owner_q;
    fifo_valid_o = lock_c & owner_valid_c;
    fifo_data_o  = lock_c ? owner_data_c : '0;
    req_ready_o  = (lock_c && fifo_ready_i) ? owner_oh_c : '0;
    beat_c       = fifo_valid_o & fifo_ready_i;
  end

  // Arbitration FSM; clear behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= RR_RST;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      grant_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found_c) begin
            state_q  <= ST_LOCK;
            owner_q  <= pick_idx_c;
            rr_ptr_q <= pick_idx_c;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            grant_q  <= NUM_REQ'(1) << pick_idx_c;
          end
        end
        ST_LOCK: begin
          if (beat_c) begin
            if (owner_last_c || (cnt_q == LAST_CNT)) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              grant_q <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_spi_master_fifo_wr_arbiter.sv
// Bench for the SPI TX FIFO write-port arbiter: cycle vector table plus
// scoreboard-checked streaming scenarios.
module tb_spi_master_fifo_wr_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clr;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_valid;
  logic [DW-1:0]   fifo_data;
  logic            fifo_ready;
  logic [NR-1:0]   grant;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_master_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
    .req_ready_o(req_ready), .fifo_valid_o(fifo_valid), .fifo_data_o(fifo_data),
    .fifo_ready_i(fifo_ready), .grant_o(grant), .busy_o(busy)
  );

  typedef struct {
    logic       clr;
    logic [1:0] v;
    logic [1:0] l;
    logic       fr;
    logic [1:0] g;
    logic       b;
    logic       fv;
    logic [1:0] rdy;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  vec_t        tbl [25];
  word_t       rq0 [$];
  word_t       rq1 [$];
  logic [31:0] exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk); #1;
    rst_n = 1'b0; clr = 1'b0; fifo_ready = 1'b1;
    req_valid = 2'b11; req_last = 2'b00; req_data = '0;
    @(posedge clk); #1;
    if (check) begin
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_fifo_valid", 64'(fifo_valid), 64'd0);
      chk("rst_fifo_data", 64'(fifo_data), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Requesters drive their queue heads; the FIFO side pops the scoreboard.
  task automatic run(input int n, input int s0, input int s1, input bit rnd);
    int c = 0;
    while (c < n && exp_q.size() > 0) begin
      @(posedge clk); #1;
      req_valid = 2'b00; req_last = 2'b00; req_data = '0;
      if (c >= s0 && rq0.size() > 0) begin
        req_valid[0] = 1'b1; req_last[0] = rq0[0].l; req_data[31:0] = rq0[0].d;
      end
      if (c >= s1 && rq1.size() > 0) begin
        req_valid[1] = 1'b1; req_last[1] = rq1[0].l; req_data[63:32] = rq1[0].d;
      end
      fifo_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      #1;
      chk("ready_outside_grant", 64'(req_ready & ~grant), 64'd0);
      if (fifo_valid && fifo_ready) begin
        chk("fifo_word", 64'(fifo_data), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (req_valid[0] && req_ready[0]) void'(rq0.pop_front());
      if (req_valid[1] && req_ready[1]) void'(rq1.pop_front());
      c++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0, w1, ed;
    //        clr  v      l      fr    g      b     fv    rdy
    tbl[0]  = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[2]  = '{1'b0, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
    tbl[3]  = '{1'b0, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
    tbl[4]  = '{1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
    tbl[5]  = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[6]  = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[7]  = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10};
    tbl[8]  = '{1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00};
    tbl[9]  = '{1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00};
    tbl[10] = '{1'b0, 2'b01, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10};
    tbl[11] = '{1'b0, 2'b01, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10};
    tbl[12] = '{1'b0, 2'b11, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10};
    tbl[13] = '{1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[14] = '{1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
    tbl[15] = '{1'b0, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[16] = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10};
    tbl[17] = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[18] = '{1'b0, 2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
    tbl[19] = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[20] = '{1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[21] = '{1'b1, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
    tbl[22] = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[23] = '{1'b0, 2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
    tbl[24] = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};

    rst_n = 1'b0; clr = 1'b0; fifo_ready = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;

    // Cycle vectors: single burst, stall, owner gaps, clear mid-burst.
    do_reset(1'b1);
    for (int r = 0; r < 25; r++) begin
      @(posedge clk); #1;
      w0 = 32'hA000_0000 + 32'(r);
      w1 = 32'hB000_0000 + 32'(r);
      clr = tbl[r].clr; req_valid = tbl[r].v; req_last = tbl[r].l;
      fifo_ready = tbl[r].fr; req_data = {w1, w0};
      #1;
      ed = tbl[r].g[0] ? w0 : (tbl[r].g[1] ? w1 : 32'd0);
      chk($sformatf("row%0d_grant", r), 64'(grant), 64'(tbl[r].g));
      chk($sformatf("row%0d_busy", r), 64'(busy), 64'(tbl[r].b));
      chk($sformatf("row%0d_fifo_valid", r), 64'(fifo_valid), 64'(tbl[r].fv));
      chk($sformatf("row%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
      chk($sformatf("row%0d_fifo_data", r), 64'(fifo_data), 64'(ed));
    end
    clr = 1'b0;

    // Both requesters always valid: bursts alternate, random FIFO backpressure.
    do_reset(1'b0);
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 2; w++) begin
        rq0.push_back('{32'hA000_0000 | 32'(b << 8) | 32'(w), (w == 1)});
        exp_q.push_back(32'hA000_0000 | 32'(b << 8) | 32'(w));
      end
      for (int w = 0; w < 3; w++) begin
        rq1.push_back('{32'hB000_0000 | 32'(b << 8) | 32'(w), (w == 2)});
        exp_q.push_back(32'hB000_0000 | 32'(b << 8) | 32'(w));
      end
    end
    run(200, 0, 0, 1'b1);

    // Long req1 stream is cut after MAX_BURST beats so req0 gets a turn.
    do_reset(1'b0);
    rq0.delete(); rq1.delete(); exp_q.delete();
    for (int w = 0; w < 40; w++) rq1.push_back('{32'hB100_0000 + 32'(w), 1'b0});
    for (int w = 0; w < 3; w++) rq0.push_back('{32'hA100_0000 + 32'(w), (w == 2)});
    for (int w = 0; w < 16; w++) exp_q.push_back(32'hB100_0000 + 32'(w));
    for (int w = 0; w < 3; w++) exp_q.push_back(32'hA100_0000 + 32'(w));
    for (int w = 16; w < 40; w++) exp_q.push_back(32'hB100_0000 + 32'(w));
    run(100, 5, 0, 1'b0);

    // req1 ran dry without a last beat: it keeps the port.
    @(posedge clk); #1;
    req_valid = 2'b00; req_last = 2'b00; fifo_ready = 1'b1;
    @(posedge clk); #2;
    chk("hold_busy", 64'(busy), 64'd1);
    chk("hold_grant", 64'(grant), 64'h2);
    chk("hold_fifo_valid", 64'(fifo_valid), 64'd0);

    // Reset from a locked state clears ownership.
    do_reset(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
